issue_warp_sched: RTL and testbench

- Per-issue-slot warp scheduler between the instruction buffer and the scoreboard.
- Arbitrates NUM_REQS per-warp instruction streams onto one issue lane.
- Grants are round-robin, with a starvation override.
- The selected instruction is held in a single registered output stage that sustains full throughput (one instruction per cycle).

---
 rtl/issue_warp_sched.sv | 133 +++++++++++++
 tb/tb_issue_warp_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_warp_sched.sv
// Per-issue-slot warp scheduler: round-robin grant with starvation override feeding one
// registered output stage. Define ISSUE_SCHED_PERF_EN to add the perf_* counter outputs.
module issue_warp_sched #(
    parameter  int NUM_REQS     = 4,
    parameter  int DATAW        = 64,
    parameter  int STARVE_LIMIT = 15,
    localparam int IDXW         = $clog2(NUM_REQS),
    localparam int CNTW         = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    input  logic [NUM_REQS-1:0]       stall_mask,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic [IDXW-1:0]           out_idx,
`ifdef ISSUE_SCHED_PERF_EN
    output logic [43:0]               perf_stalls,
    output logic [43:0]               perf_starve_grants,
`endif
    input  logic                      out_ready
);

    localparam logic [CNTW-1:0] SAT = CNTW'(STARVE_LIMIT);

    logic                out_valid_q;
    logic [DATAW-1:0]    out_data_q;
    logic [IDXW-1:0]     out_idx_q;
    logic [IDXW-1:0]     rr_ptr_q;
    logic [CNTW-1:0]     wait_cnt_q [NUM_REQS];
    logic [CNTW-1:0]     wait_cnt_d [NUM_REQS];

    logic [NUM_REQS-1:0] elig;
    logic [NUM_REQS-1:0] gnt;
    logic                any_elig;
    logic                load;
    logic                fire;
    logic                starve_hit;
    logic [IDXW-1:0]     starve_idx;
    logic [IDXW-1:0]     rr_idx;
    logic [IDXW-1:0]     cand;
    logic [IDXW-1:0]     gnt_idx;
    logic [DATAW-1:0]    sel_data;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        elig       = req_valid & ~stall_mask;
        any_elig   = |elig;
        load       = ~out_valid_q | out_ready;
        fire       = load & any_elig;
        starve_hit = 1'b0;
        starve_idx = '0;
        rr_idx     = '0;
        cand       = '0;
        gnt        = '0;

        // Downward scan so the lowest starving index is the one left standing.
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (elig[i] && wait_cnt_q[i] == SAT) begin
                starve_hit = 1'b1;
                starve_idx = IDXW'(i);
            end
        end

        // Offsets NUM_REQS..1 from rr_ptr; the smallest eligible offset is written last and wins.
        for (int k = NUM_REQS; k >= 1; k--) begin
            cand = rr_ptr_q + IDXW'(k);
            if (elig[cand]) rr_idx = cand;
        end

        gnt_idx = starve_hit ? starve_idx : rr_idx;
        if (any_elig) gnt[gnt_idx] = 1'b1;
        sel_data  = req_data[int'(gnt_idx)*DATAW +: DATAW];
        req_ready = (load && reset) ? gnt : '0;

        for (int i = 0; i < NUM_REQS; i++) begin
            if (!req_valid[i] || (fire && gnt_idx == IDXW'(i))) begin
                wait_cnt_d[i] = '0;
            end else if (elig[i] && wait_cnt_q[i] != SAT) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
            end else begin
                wait_cnt_d[i] = wait_cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            rr_ptr_q    <= IDXW'(NUM_REQS - 1);
            // NOTE: the wait counters are a handful of flops, not a RAM, so each one is reset.
            for (int i = 0; i < NUM_REQS; i++) wait_cnt_q[i] <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
            if (load) begin
                out_valid_q <= any_elig;
                if (any_elig) begin
                    out_data_q <= sel_data;
                    out_idx_q  <= gnt_idx;
                    rr_ptr_q   <= gnt_idx;
                end
            end
            for (int i = 0; i < NUM_REQS; i++) wait_cnt_q[i] <= wait_cnt_d[i];
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;

`ifdef ISSUE_SCHED_PERF_EN
    logic [43:0] perf_stalls_q;
    logic [43:0] perf_starve_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stalls_q <= '0;
            perf_starve_q <= '0;
        end else begin
            if (any_elig && !load)   perf_stalls_q <= perf_stalls_q + 44'd1;
            if (fire && starve_hit)  perf_starve_q <= perf_starve_q + 44'd1;
        end
    end

    assign perf_stalls        = perf_stalls_q;
    assign perf_starve_grants = perf_starve_q;
`endif

endmodule

// File: tb/tb_issue_warp_sched.sv
// Directed bench for issue_warp_sched: an abstract arbitration model checked every cycle,
// plus literal expectations for the grant order in each scenario.
module tb_issue_warp_sched;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int SL = 15;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      stall_mask = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic              out_ready = 1'b0;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_idx;
`ifdef ISSUE_SCHED_PERF_EN
    logic [43:0]       perf_stalls;
    logic [43:0]       perf_starve_grants;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_warp_sched #(.NUM_REQS(N), .DATAW(DW), .STARVE_LIMIT(SL)) dut (
        .clk                (clk),
        .reset              (rst_n),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_ready          (req_ready),
        .stall_mask         (stall_mask),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .out_idx            (out_idx),
`ifdef ISSUE_SCHED_PERF_EN
        .perf_stalls        (perf_stalls),
        .perf_starve_grants (perf_starve_grants),
`endif
        .out_ready          (out_ready)
    );

    // ---------------- behavioural model ----------------
    int            m_wait [N];
    int            m_ptr  = N - 1;
    bit            m_ov   = 1'b0;
    logic [DW-1:0] m_od   = '0;
    int            m_oi   = 0;
    longint        m_stalls = 0;
    longint        m_sg     = 0;

    logic [N-1:0]  u_e;
    int            u_g;
    bit            u_ld;

    function automatic bit starving(input logic [N-1:0] e);
        for (int i = 0; i < N; i++) if (e[i] && m_wait[i] == SL) return 1'b1;
        return 1'b0;
    endfunction

    // Chosen warp for eligibility vector e, or -1 when nobody is eligible.
    function automatic int pick(input logic [N-1:0] e);
        for (int i = 0; i < N; i++) if (e[i] && m_wait[i] == SL) return i;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (e[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] e;
        int           g;
        e = req_valid & ~stall_mask;
        g = pick(e);
        if (!rst_n || !(!m_ov || out_ready) || g < 0) return '0;
        return N'(1) << g;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        m_ptr = N - 1; m_ov = 1'b0; m_od = '0; m_oi = 0; m_stalls = 0; m_sg = 0;
    endtask

    initial for (int i = 0; i < N; i++) m_wait[i] = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            u_e  = req_valid & ~stall_mask;
            u_g  = pick(u_e);
            u_ld = !m_ov || out_ready;
            if (u_ld) begin
                if (u_g >= 0) begin
                    if (starving(u_e)) m_sg++;
                    m_ov  = 1'b1;
                    m_od  = req_data[u_g*DW +: DW];
                    m_oi  = u_g;
                    m_ptr = u_g;
                end else begin
                    m_ov = 1'b0;
                end
            end else if (u_e != '0) begin
                m_stalls++;
            end
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || (u_ld && u_g == i)) m_wait[i] = 0;
                else if (u_e[i] && m_wait[i] < SL)       m_wait[i]++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, on the inactive clock edge.
    always @(negedge clk) begin
        check("m_req_ready", 64'(req_ready), 64'(exp_ready()));
        check("m_out_valid", 64'(out_valid), 64'(m_ov));
        check("m_out_data",  64'(out_data),  64'(m_od));
        check("m_out_idx",   64'(out_idx),   64'(m_oi));
`ifdef ISSUE_SCHED_PERF_EN
        check("m_perf_stalls", 64'(perf_stalls),        64'(m_stalls));
        check("m_perf_starve", 64'(perf_starve_grants), 64'(m_sg));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ph);
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(16'h1000 * (i + 1) + ph);
    endtask

    initial begin
        // Reset with every warp requesting, then round-robin from warp 0.
        set_data(0);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'(4'b0000));
        check("rst_valid", 64'(out_valid), 64'(1'b0));
        rst_n = 1'b1;
        #1;
        check("rr_g0", 64'(req_ready), 64'(4'b0001));
        tick();
        check("rr_idx0",  64'(out_idx),  64'(0));
        check("rr_data0", 64'(out_data), 64'(16'h1000));
        check("rr_g1",    64'(req_ready), 64'(4'b0010));
        tick();
        check("rr_idx1", 64'(out_idx),   64'(1));
        check("rr_g2",   64'(req_ready), 64'(4'b0100));
        tick();
        check("rr_idx2", 64'(out_idx),   64'(2));
        check("rr_g3",   64'(req_ready), 64'(4'b1000));
        tick();
        check("rr_idx3", 64'(out_idx),   64'(3));
        check("rr_g0b",  64'(req_ready), 64'(4'b0001));

        // Two odd warps alternate; masking warp 1 leaves only warp 3.
        set_data(1);
        req_valid = 4'b1010;
        #1;
        check("alt_g1", 64'(req_ready), 64'(4'b0010));
        tick();
        check("alt_idx1", 64'(out_idx),   64'(1));
        check("alt_g3",   64'(req_ready), 64'(4'b1000));
        tick();
        check("alt_idx3", 64'(out_idx),   64'(3));
        check("alt_g1b",  64'(req_ready), 64'(4'b0010));
        tick();
        check("alt_idx1b", 64'(out_idx), 64'(1));
        stall_mask = 4'b0010;
        #1;
        check("mask_g3", 64'(req_ready), 64'(4'b1000));
        tick();
        check("mask_idx3", 64'(out_idx),   64'(3));
        check("mask_g3b",  64'(req_ready), 64'(4'b1000));
        tick();

        // Drain, then back-pressure right after an accept.
        stall_mask = '0;
        req_valid  = '0;
        tick();
        check("drain_valid", 64'(out_valid), 64'(1'b0));
        set_data(2);
        req_valid = 4'b0101;
        out_ready = 1'b0;
        #1;
        check("bp_g0", 64'(req_ready), 64'(4'b0001));
        tick();
        for (int c = 0; c < 3; c++) begin
            check("bp_ready0", 64'(req_ready), 64'(4'b0000));
            check("bp_idx0",   64'(out_idx),   64'(0));
            check("bp_data0",  64'(out_data),  64'(16'h1002));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_g2", 64'(req_ready), 64'(4'b0100));
        tick();
        check("bp_idx2",   64'(out_idx),   64'(2));
        check("bp_valid2", 64'(out_valid), 64'(1'b1));

        // Warps 2 and 3 saturate behind a full output stage; starvation beats round-robin.
        out_ready = 1'b0;
        req_valid = 4'b1100;
        set_data(3);
        repeat (16) tick();
        check("st_hold_idx", 64'(out_idx), 64'(2));
        out_ready = 1'b1;
        #1;
        check("st_g2", 64'(req_ready), 64'(4'b0100));
        tick();
        check("st_idx2", 64'(out_idx),   64'(2));
        check("st_g3",   64'(req_ready), 64'(4'b1000));
        tick();
        check("st_idx3", 64'(out_idx), 64'(3));
        req_valid = 4'b1101;
        #1;
        check("st_rr_g0", 64'(req_ready), 64'(4'b0001));
        tick();
        check("st_rr_idx0", 64'(out_idx),   64'(0));
        check("st_rr_g2",   64'(req_ready), 64'(4'b0100));
`ifdef ISSUE_SCHED_PERF_EN
        check("perf_starve2", 64'(perf_starve_grants), 64'(2));
`endif

        // Asynchronous reset while holding an instruction.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'(1'b0));
        check("ar_ready", 64'(req_ready), 64'(4'b0000));
        check("ar_idx",   64'(out_idx),   64'(0));
        repeat (2) tick();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("ar_g0", 64'(req_ready), 64'(4'b0001));
        tick();
        check("ar_idx0", 64'(out_idx), 64'(0));

        // Lone warp 0 gets every cycle.
        req_valid = 4'b0001;
        #1;
        for (int c = 0; c < 20; c++) begin
            check("solo_g0", 64'(req_ready), 64'(4'b0001));
            tick();
            check("solo_idx0", 64'(out_idx), 64'(0));
        end
`ifdef ISSUE_SCHED_PERF_EN
        check("perf_stalls0", 64'(perf_stalls), 64'(0));
`endif
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
